// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor controller.
package bp_pkg;

  // Mispredict recovery sequencing
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } bp_state_e;

  // Control-flow opcodes (RV32 major opcodes)
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // 2-bit saturating counter encodings
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [1:0] {
    UPD_BR   = 2'd0,
    UPD_JAL  = 2'd1,
    UPD_JALR = 2'd2
  } upd_kind_e;

  // Table write request produced at a resolve event
  typedef struct packed {
    logic        en;
    upd_kind_e   kind;
    logic [31:0] pc;
    logic        taken;
    logic [29:0] target;
  } bp_upd_t;

  // Saturating step of a 2-bit counter
  function automatic logic [1:0] sat_next(input logic [1:0] c, input logic up);
    if (up) return (c == ST)  ? ST  : c + 2'd1;
    else    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped branch history/target table: combinational lookup, update on
// the clock edge with no write-to-read bypass.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lk_pc,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  bp_upd_t     upd
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]            vld;
  logic [ENTRIES-1:0][TAG_W-1:0] tag;
  logic [ENTRIES-1:0][29:0]      tgt;
  logic [ENTRIES-1:0][1:0]       ctr;

  logic [IDX_W-1:0] lk_idx, u_idx;
  logic             lk_hit, u_hit;

  // Lookup and update-side hit detection
  always_comb begin
    lk_idx    = lk_pc[IDX_W+1:2];
    lk_hit    = vld[lk_idx] && (tag[lk_idx] == lk_pc[31:IDX_W+2]);
    lk_taken  = lk_hit && ctr[lk_idx][1];
    lk_target = lk_hit ? {tgt[lk_idx], 2'b00} : lk_pc + 32'd4;
    u_idx     = upd.pc[IDX_W+1:2];
    u_hit     = vld[u_idx] && (tag[u_idx] == upd.pc[31:IDX_W+2]);
  end

  // Entry storage: train counters, allocate on taken/JAL, drop JALR entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      tag <= '0;
      tgt <= '0;
      ctr <= {ENTRIES{WNT}};
    end else if (upd.en) begin
      case (upd.kind)
        UPD_BR: begin
          if (u_hit) begin
            ctr[u_idx] <= sat_next(ctr[u_idx], upd.taken);
          end else if (upd.taken) begin
            vld[u_idx] <= 1'b1;
            tag[u_idx] <= upd.pc[31:IDX_W+2];
            tgt[u_idx] <= upd.target;
            ctr[u_idx] <= WT;
          end
        end
        UPD_JAL: begin
          vld[u_idx] <= 1'b1;
          tag[u_idx] <= upd.pc[31:IDX_W+2];
          tgt[u_idx] <= upd.target;
          ctr[u_idx] <= ST;
        end
        UPD_JALR: begin
          if (u_hit) vld[u_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor controller: fetch lookup, execute-stage resolve, mispredict
// flush/redirect sequencing. Optional perf counters under BRANCH_PERF_CNT_EN.
module branch_pred_ctrl
  import bp_pkg::*;
#(
  parameter int BHT_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [6:0]  ex_opcode,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_miss_cnt
);
  bp_state_e state, state_nxt;
  logic      is_br, is_jal, is_jalr, resolve, taken_eff, mispred;
  bp_upd_t   upd;

  // Classify the execute-stage instruction and detect a mispredict
  always_comb begin
    is_br     = (ex_opcode == OP_BRANCH);
    is_jal    = (ex_opcode == OP_JAL);
    is_jalr   = (ex_opcode == OP_JALR);
    resolve   = ex_valid && (state == IDLE) && (is_br || is_jal || is_jalr);
    taken_eff = is_br ? ex_br_taken : 1'b1;
    mispred   = (taken_eff != ex_pred_taken) ||
                (taken_eff && ex_pred_taken && (ex_target != ex_pred_target));
    upd.en     = resolve;
    upd.kind   = is_jal ? UPD_JAL : (is_jalr ? UPD_JALR : UPD_BR);
    upd.pc     = ex_pc;
    upd.taken  = taken_eff;
    upd.target = ex_target[31:2];
  end

  bp_table #(.ENTRIES(BHT_ENTRIES)) u_table (
    .clk       (clk),
    .rst       (rst),
    .lk_pc     (if_pc),
    .lk_taken  (pred_taken),
    .lk_target (pred_target),
    .upd       (upd)
  );

  // Recovery state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and flush/redirect decode
  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    redirect  = 1'b0;
    case (state)
      IDLE:    if (resolve && mispred) state_nxt = FLUSH;
      FLUSH: begin
        flush     = 1'b1;
        redirect  = 1'b1;
        state_nxt = RECOVER;
      end
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the correct-path PC at the resolve edge; held until the next mispredict
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    redirect_pc <= '0;
    else if (resolve && mispred) redirect_pc <= taken_eff ? ex_target : ex_pc + 32'd4;
  end

`ifdef BRANCH_PERF_CNT_EN
  // Saturating resolve / mispredict event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_cnt   <= '0;
      perf_miss_cnt <= '0;
    end else if (resolve) begin
      if (perf_br_cnt != '1)               perf_br_cnt   <= perf_br_cnt + 32'd1;
      if (mispred && perf_miss_cnt != '1)  perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`else
  assign perf_br_cnt   = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Bench for branch_pred_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked against a table-level reference model.
module tb_branch_pred_ctrl;
  localparam int N  = 16;
  localparam int IW = $clog2(N);
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] if_pc = '0, ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic        ex_valid = 1'b0, ex_br_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [6:0]  ex_opcode = 7'h13;
  logic        pred_taken, flush, redirect;
  logic [31:0] pred_target, redirect_pc, perf_br_cnt, perf_miss_cnt;

  branch_pred_ctrl #(.BHT_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_br_taken(ex_br_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .perf_br_cnt(perf_br_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: per-entry fields, cycles left in recovery, last redirect target
  bit          m_v[N];
  int unsigned m_tag[N], m_tgt[N];
  int          m_ctr[N];
  int          m_left;
  int unsigned m_rpc, m_br, m_miss;
  int          n_chk = 0, n_err = 0;
  bit          chk_en = 0;

  function automatic int ix(input int unsigned pc); return (pc >> 2) % N; endfunction
  function automatic bit m_hit(input int unsigned pc);
    return m_v[ix(pc)] && m_tag[ix(pc)] == (pc >> (IW + 2));
  endfunction
  function automatic bit m_ptk(input int unsigned pc);
    return m_hit(pc) && m_ctr[ix(pc)] >= 2;
  endfunction
  function automatic int unsigned m_ptg(input int unsigned pc);
    return m_hit(pc) ? m_tgt[ix(pc)] : pc + 4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_ctr[i] = 1; end
    m_left = 0; m_rpc = 0; m_br = 0; m_miss = 0;
  endtask

  // What one rising edge does to the model, given the inputs present before it
  task automatic m_edge();
    bit tk, mis;
    int i;
    if (m_left > 0) begin
      m_left--;
    end else if (ex_valid && (ex_opcode == BR || ex_opcode == JAL || ex_opcode == JALR)) begin
      tk  = (ex_opcode == BR) ? ex_br_taken : 1'b1;
      mis = (tk != ex_pred_taken) || (tk && ex_pred_taken && ex_target != ex_pred_target);
      i   = ix(ex_pc);
      if (ex_opcode == JALR) begin
        if (m_hit(ex_pc)) m_v[i] = 0;
      end else if (ex_opcode == BR && m_hit(ex_pc)) begin
        m_ctr[i] = tk ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
      end else if (tk) begin
        m_v[i] = 1; m_tag[i] = ex_pc >> (IW + 2); m_tgt[i] = ex_target & ~32'd3;
        m_ctr[i] = (ex_opcode == JAL) ? 3 : 2;
      end
      m_br++;
      if (mis) begin
        m_miss++; m_left = 2;
        m_rpc = tk ? ex_target : ex_pc + 4;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) if (chk_en) begin
    chk("pred_taken",  {31'd0, pred_taken}, {31'd0, m_ptk(if_pc)});
    chk("pred_target", pred_target, m_ptg(if_pc));
    chk("flush",       {31'd0, flush},    {31'd0, m_left == 2});
    chk("redirect",    {31'd0, redirect}, {31'd0, m_left == 2});
    chk("redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_PERF_CNT_EN
    chk("perf_br",   perf_br_cnt,   m_br);
    chk("perf_miss", perf_miss_cnt, m_miss);
`else
    chk("perf_br",   perf_br_cnt,   32'd0);
    chk("perf_miss", perf_miss_cnt, 32'd0);
`endif
  end

  task automatic drive(input logic [31:0] ipc, input bit v, input logic [6:0] op, input logic [31:0] pc,
                       input bit bt, input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
    if_pc = ipc; ex_valid = v; ex_opcode = op; ex_pc = pc;
    ex_br_taken = bt; ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask
  task automatic idle(input logic [31:0] ipc); drive(ipc, 0, 7'h13, 0, 0, 0, 0, 0); endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_reset(); else m_edge();
    #1;
  endtask

  logic [31:0] pool [6] = '{32'h100, 32'h104, 32'h200, 32'h140, 32'h300, 32'h1100};
  logic [6:0]  ops  [5] = '{BR, BR, JAL, JALR, 7'h33};

  initial begin
    m_reset();
    #1 chk_en = 1;
    tick(); tick();
    rst = 0;
    // Reset lookup
    idle(32'h100); #1;
    chk("rst_pt", {31'd0, pred_taken}, 32'd0);
    chk("rst_tg", pred_target, 32'h104);
    chk("rst_fl", {31'd0, flush}, 32'd0);
    tick();
    // Taken BEQ mispredicted as not-taken; same-cycle lookup sees old value
    drive(32'h100, 1, BR, 32'h100, 1, 32'h80, 0, 32'h104); #1;
    chk("nobypass", {31'd0, pred_taken}, 32'd0);
    tick();
    idle(32'h100); #1;
    chk("fl1", {31'd0, flush}, 32'd1);
    chk("rpc1", redirect_pc, 32'h80);
    chk("alloc_pt", {31'd0, pred_taken}, 32'd1);
    chk("alloc_tg", pred_target, 32'h80);
    tick(); #1;
    chk("recover_fl", {31'd0, flush}, 32'd0);
    chk("recover_rd", {31'd0, redirect}, 32'd0);
    tick();
    // Correctly predicted taken: counter to strong, no flush
    drive(32'h100, 1, BR, 32'h100, 1, 32'h80, 1, 32'h80); tick(); #1;
    chk("ok_fl", {31'd0, flush}, 32'd0);
    // Five not-taken resolves: first two mispredict, then counter floors at 00
    for (int i = 0; i < 5; i++) begin
      drive(32'h100, 1, BR, 32'h100, 0, 32'h80, m_ptk(32'h100), m_ptg(32'h100)); tick();
      idle(32'h100); #1;
      chk("nt_fl", {31'd0, flush}, {31'd0, i < 2});
      tick(); tick();
    end
    chk("nt_pt", {31'd0, pred_taken}, 32'd0);
    // JALR: redirect, never installed
    drive(32'h200, 1, JALR, 32'h200, 0, 32'h300, 0, 32'h204); tick();
    idle(32'h200); #1;
    chk("jalr_fl", {31'd0, flush}, 32'd1);
    chk("jalr_rpc", redirect_pc, 32'h300);
    chk("jalr_pt", {31'd0, pred_taken}, 32'd0);
    chk("jalr_tg", pred_target, 32'h204);
    tick(); tick();
    // Mispredict, second mispredict during FLUSH, then reset mid-FLUSH
    drive(32'h140, 1, BR, 32'h140, 1, 32'h40, 0, 32'h144); tick();
    drive(32'h300, 1, JAL, 32'h300, 0, 32'h500, 0, 32'h304); #1;
    chk("f2_fl", {31'd0, flush}, 32'd1);
    #1 rst = 1; m_reset(); #1;
    chk("abort_fl", {31'd0, flush}, 32'd0);
    chk("abort_rpc", redirect_pc, 32'd0);
    tick();
    rst = 0; idle(32'h140); tick(); #1;
    chk("post_fl", {31'd0, flush}, 32'd0);
    chk("clr_pt", {31'd0, pred_taken}, 32'd0);
    chk("clr_tg", pred_target, 32'h144);
    // Ten resolves, three mispredicts
    for (int i = 0; i < 7; i++) begin drive(32'h400, 1, BR, 32'h400, 0, 32'h480, 0, 32'h404); tick(); end
    for (int i = 0; i < 3; i++) begin
      drive(32'h400, 1, BR, 32'h400, 1, 32'h480, 0, 32'h404); tick();
      idle(32'h400); tick(); tick();
    end
    #1;
`ifdef BRANCH_PERF_CNT_EN
    chk("perf10", perf_br_cnt, 32'd10);
    chk("perf3",  perf_miss_cnt, 32'd3);
`else
    chk("perf10", perf_br_cnt, 32'd0);
    chk("perf3",  perf_miss_cnt, 32'd0);
`endif
    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc, tg;
      logic [6:0]  op;
      pc = pool[$urandom_range(0, 5)];
      op = ops[$urandom_range(0, 4)];
      tg = (op == JALR) ? ($urandom & 32'h0000fffc) : (op == JAL ? pc + 32'h80 : pc - 32'h40);
      if ($urandom_range(0, 3) != 0)
        drive(pool[$urandom_range(0, 5)], $urandom_range(0, 6) != 0, op, pc, $urandom_range(0, 1),
              tg, m_ptk(pc), m_ptg(pc));
      else
        drive(pool[$urandom_range(0, 5)], $urandom_range(0, 6) != 0, op, pc, $urandom_range(0, 1),
              tg, $urandom_range(0, 1), $urandom & 32'h0000fffc);
      if ($urandom_range(0, 149) == 0) begin rst = 1; m_reset(); end
      tick();
      rst = 0;
    end
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
